// File: rtl/fib_pkg.sv
// ----------------------------------------------------------------------------
// fib_pkg
// Shared definitions for the Fibonacci command front-end and its consumers.
//   DW          : width of an index and of a Fibonacci value
//   MAX_N       : largest index whose value still fits in DW bits
//   seq_state_t : sequencer FSM states
//   fib_res_t   : one tagged result {index, value, overflow flag}
// ----------------------------------------------------------------------------
package fib_pkg;

    localparam int DW    = 16;
    localparam int MAX_N = 24;    // fib(24) = 46368, fib(25) = 75025 > 2^16-1

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } seq_state_t;

    typedef struct packed {
        logic [DW-1:0] n;
        logic [DW-1:0] value;
        logic          ovf;
    } fib_res_t;

endpackage

// File: rtl/fib_result_fifo.sv
// ----------------------------------------------------------------------------
// fib_result_fifo
// First-word-fall-through result buffer. The head entry is presented
// combinationally; an empty FIFO presents all-zero data.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset (flushes the FIFO)
//   push, push_data : write one entry (ignored when full unless also popping)
//   pop             : remove the head entry (ignored when empty)
//   head            : head entry, '0 when empty
//   empty, full     : occupancy flags
// ----------------------------------------------------------------------------
module fib_result_fifo
    import fib_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  fib_res_t push_data,
    input  logic     pop,
    output fib_res_t head,
    output logic     empty,
    output logic     full
);

    localparam int AW = $clog2(DEPTH);

    fib_res_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot the push lands in, so push-while-full is legal
    // when a pop happens in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // NOTE: the storage array has no reset; validity is tracked by count, and
    // the head is masked to zero while empty so stale contents never leak.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fib_sequencer.sv
// ----------------------------------------------------------------------------
// fib_sequencer
// Range-command front-end for the Fibonacci engine. Walks indices first..last,
// starts the engine once per in-range index, captures each result on done and
// queues {index, value, ovf} in a FWFT result FIFO. Indices above MAX_N are
// not sent to the engine; they are queued with ovf=1 and value 0.
// Ports:
//   clk, reset                     : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            : range command handshake
//   cmd_first, cmd_last            : inclusive index range
//   fib_start, fib_din             : engine start pulse and index
//   fib_dout, fib_done             : engine result and completion pulse
//   res_valid/res_ready            : result handshake
//   res_n, res_value, res_ovf      : head result
//   busy                           : command in progress
//   timeout_err                    : sticky engine-timeout flag
// ----------------------------------------------------------------------------
module fib_sequencer
    import fib_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_first,
    input  logic [DW-1:0] cmd_last,
    output logic          fib_start,
    output logic [DW-1:0] fib_din,
    input  logic [DW-1:0] fib_dout,
    input  logic          fib_done,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_n,
    output logic [DW-1:0] res_value,
    output logic          res_ovf,
    output logic          busy,
    output logic          timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    seq_state_t    state;
    logic [DW-1:0] cur;
    logic [DW-1:0] last_idx;
    logic [TW-1:0] timer;

    logic          cur_ovf;
    logic          at_last;
    logic          push;
    fib_res_t      push_data;
    fib_res_t      head;
    logic          fifo_empty;
    logic          fifo_full;

    assign cur_ovf = (cur > DW'(MAX_N));
    assign at_last = (cur == last_idx);
    assign busy    = (state != IDLE);

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        case (state)
            ISSUE: begin
                if (!fifo_full && cur_ovf) begin
                    push      = 1'b1;
                    push_data = '{n: cur, value: '0, ovf: 1'b1};
                end
            end
            WAIT: begin
                // Space was reserved when the index was issued.
                if (fib_done) begin
                    push      = 1'b1;
                    push_data = '{n: cur, value: fib_dout, ovf: 1'b0};
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; later assignments in the block override earlier
    // defaults within the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            cur         <= '0;
            last_idx    <= '0;
            timer       <= '0;
            fib_start   <= 1'b0;
            fib_din     <= '0;
            timeout_err <= 1'b0;
        end else begin
            fib_start <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cur         <= cmd_first;
                        last_idx    <= cmd_last;
                        timeout_err <= 1'b0;
                        // An empty range is consumed without leaving IDLE.
                        if (cmd_first <= cmd_last) begin
                            state     <= ISSUE;
                            cmd_ready <= 1'b0;
                        end
                    end
                end

                ISSUE: begin
                    if (!fifo_full) begin
                        if (cur_ovf) begin
                            // Advance; equality test before increment means
                            // cur never wraps, even for last = 2^DW-1.
                            if (at_last) begin
                                state     <= IDLE;
                                cmd_ready <= 1'b1;
                            end else begin
                                cur   <= cur + 1'b1;
                                state <= ISSUE;
                            end
                        end else begin
                            fib_start <= 1'b1;
                            fib_din   <= cur;
                            timer     <= TW'(TIMEOUT);
                            state     <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    // done has priority over an expiry in the same cycle.
                    if (fib_done) begin
                        if (at_last) begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                        end else begin
                            cur   <= cur + 1'b1;
                            state <= ISSUE;
                        end
                    end else if (timer <= TW'(1)) begin
                        timer       <= '0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                        cmd_ready   <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    fib_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (res_ready),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign res_valid = !fifo_empty;
    assign res_n     = head.n;
    assign res_value = head.value;
    assign res_ovf   = head.ovf;

endmodule

// File: tb/tb_fib_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fib_sequencer
// Self-checking bench for fib_sequencer with a behavioural engine model.
// ----------------------------------------------------------------------------
module tb_fib_sequencer;
    import fib_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [15:0]   cmd_first = '0;
    logic [15:0]   cmd_last = '0;
    logic          fib_start;
    logic [15:0]   fib_din;
    logic [15:0]   fib_dout;
    logic          fib_done;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [15:0]   res_n;
    logic [15:0]   res_value;
    logic          res_ovf;
    logic          busy;
    logic          timeout_err;

    always #5 clk = ~clk;

    fib_sequencer #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_first   (cmd_first),
        .cmd_last    (cmd_last),
        .fib_start   (fib_start),
        .fib_din     (fib_din),
        .fib_dout    (fib_dout),
        .fib_done    (fib_done),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_n       (res_n),
        .res_value   (res_value),
        .res_ovf     (res_ovf),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- engine model: done 3 cycles after start ----------------
    function automatic logic [15:0] fib_calc(input logic [15:0] n);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] t;
        a = 16'd0;
        b = 16'd1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    logic        engine_en = 1'b1;
    logic        eng_pend;
    int          eng_cnt;
    logic [15:0] eng_n;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            eng_pend = 1'b0;
            eng_cnt  = 0;
            eng_n    = '0;
            fib_done = 1'b0;
            fib_dout = '0;
        end else begin
            fib_done = 1'b0;
            if (fib_start) begin
                eng_pend = 1'b1;
                eng_cnt  = 2;
                eng_n    = fib_din;
            end else if (eng_pend) begin
                if (eng_cnt == 0) begin
                    eng_pend = 1'b0;
                    if (engine_en) begin
                        fib_done = 1'b1;
                        fib_dout = fib_calc(eng_n);
                    end
                end else begin
                    eng_cnt--;
                end
            end
        end
    end

    // ---------------- monitors ----------------
    int       starts = 0;
    fib_res_t got[$];

    always @(negedge clk) begin
        if (fib_start) starts++;
        if (res_valid && res_ready) got.push_back('{n: res_n, value: res_value, ovf: res_ovf});
    end

    // ---------------- tables ----------------
    typedef struct {
        logic [15:0] first;
        logic [15:0] last;
        int          exp_starts;
        int          exp_base;
        int          exp_cnt;
    } vec_t;

    fib_res_t exp_tab[16];
    vec_t     vecs[5];

    task automatic issue_cmd(input logic [15:0] first, input logic [15:0] last);
        int k;
        @(posedge clk);
        #1;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("cmd_ready before issue", 32'(cmd_ready), 32'd1);
        cmd_first = first;
        cmd_last  = last;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int g0, input int cnt);
        int k;
        k = 0;
        while (!(!busy && (got.size() - g0) >= cnt) && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) check("completion within budget", 32'd0, 32'd1);
    endtask

    task automatic check_results(input string tag, input int g0, input int base, input int cnt);
        check({tag, " result count"}, 32'(got.size() - g0), 32'(cnt));
        for (int i = 0; i < cnt && (g0 + i) < got.size(); i++) begin
            check($sformatf("%s res[%0d].n", tag, i),     32'(got[g0+i].n),     32'(exp_tab[base+i].n));
            check($sformatf("%s res[%0d].value", tag, i), 32'(got[g0+i].value), 32'(exp_tab[base+i].value));
            check($sformatf("%s res[%0d].ovf", tag, i),   32'(got[g0+i].ovf),   32'(exp_tab[base+i].ovf));
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int s0;
        int g0;
        s0 = starts;
        g0 = got.size();
        issue_cmd(v.first, v.last);
        @(negedge clk);
        check({tag, " busy after accept"}, 32'(busy), 32'(v.first <= v.last));
        check({tag, " cmd_ready after accept"}, 32'(cmd_ready), 32'(v.first > v.last));
        @(negedge clk);
        check({tag, " fib_start 1 cycle after accept"}, 32'(fib_start), 32'(v.exp_starts > 0));
        wait_done(g0, v.exp_cnt);
        repeat (4) @(negedge clk);
        check({tag, " fib_start count"}, 32'(starts - s0), 32'(v.exp_starts));
        check({tag, " busy at end"}, 32'(busy), 32'd0);
        check({tag, " cmd_ready at end"}, 32'(cmd_ready), 32'd1);
        check_results(tag, g0, v.exp_base, v.exp_cnt);
    endtask

    initial begin
        int s0;
        int s1;
        int g0;
        int k;

        // Hand-computed expected results.
        exp_tab[0]  = '{n: 16'd0,     value: 16'd0,     ovf: 1'b0};
        exp_tab[1]  = '{n: 16'd1,     value: 16'd1,     ovf: 1'b0};
        exp_tab[2]  = '{n: 16'd2,     value: 16'd1,     ovf: 1'b0};
        exp_tab[3]  = '{n: 16'd3,     value: 16'd2,     ovf: 1'b0};
        exp_tab[4]  = '{n: 16'd4,     value: 16'd3,     ovf: 1'b0};
        exp_tab[5]  = '{n: 16'd5,     value: 16'd5,     ovf: 1'b0};
        exp_tab[6]  = '{n: 16'd6,     value: 16'd8,     ovf: 1'b0};
        exp_tab[7]  = '{n: 16'd7,     value: 16'd13,    ovf: 1'b0};
        exp_tab[8]  = '{n: 16'd8,     value: 16'd21,    ovf: 1'b0};
        exp_tab[9]  = '{n: 16'd9,     value: 16'd34,    ovf: 1'b0};
        exp_tab[10] = '{n: 16'd23,    value: 16'd28657, ovf: 1'b0};
        exp_tab[11] = '{n: 16'd24,    value: 16'd46368, ovf: 1'b0};
        exp_tab[12] = '{n: 16'd25,    value: 16'd0,     ovf: 1'b1};
        exp_tab[13] = '{n: 16'd26,    value: 16'd0,     ovf: 1'b1};
        exp_tab[14] = '{n: 16'd65534, value: 16'd0,     ovf: 1'b1};
        exp_tab[15] = '{n: 16'd65535, value: 16'd0,     ovf: 1'b1};

        //                first     last      starts base cnt
        vecs[0] = '{16'd0,     16'd5,     6, 0,  6};
        vecs[1] = '{16'd23,    16'd26,    2, 10, 4};
        vecs[2] = '{16'd7,     16'd3,     0, 0,  0};
        vecs[3] = '{16'd65534, 16'd65535, 0, 14, 2};
        vecs[4] = '{16'd24,    16'd24,    1, 11, 1};

        // ---- reset state ----
        #2;
        check("reset cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset fib_start", 32'(fib_start), 32'd0);
        check("reset fib_din", 32'(fib_din), 32'd0);
        check("reset res_n", 32'(res_n), 32'd0);
        check("reset timeout_err", 32'(timeout_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("cmd_ready after reset release", 32'(cmd_ready), 32'd1);

        // ---- table-driven ranges ----
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // ---- FIFO full stall, then drain ----
        res_ready = 1'b0;
        s0 = starts;
        g0 = got.size();
        issue_cmd(16'd0, 16'd9);
        repeat (40) @(negedge clk);
        check("full: starts before stall", 32'(starts - s0), 32'd4);
        check("full: res_valid", 32'(res_valid), 32'd1);
        check("full: busy while stalled", 32'(busy), 32'd1);
        check("full: nothing popped", 32'(got.size() - g0), 32'd0);
        check("full: head is index 0", 32'(res_n), 32'd0);
        s1 = starts;
        repeat (20) @(negedge clk);
        check("full: no start while stalled", 32'(starts - s1), 32'd0);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_done(g0, 10);
        repeat (4) @(negedge clk);
        check("full: total starts", 32'(starts - s0), 32'd10);
        check_results("full", g0, 0, 10);

        // ---- engine timeout ----
        @(posedge clk);
        #1;
        engine_en = 1'b0;
        s0 = starts;
        issue_cmd(16'd5, 16'd8);
        k = 0;
        while (!fib_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("timeout: fib_start seen", 32'(fib_start), 32'd1);
        k = 0;
        while (!timeout_err && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("timeout: cycles start to timeout_err", 32'(k), 32'd64);
        @(negedge clk);
        check("timeout: busy after", 32'(busy), 32'd0);
        check("timeout: cmd_ready after", 32'(cmd_ready), 32'd1);
        check("timeout: timeout_err sticky", 32'(timeout_err), 32'd1);
        check("timeout: rest of range dropped", 32'(starts - s0), 32'd1);
        engine_en = 1'b1;
        issue_cmd(16'd7, 16'd3);
        check("timeout: cleared by next accept", 32'(timeout_err), 32'd0);

        // ---- reset during WAIT with 2 results queued ----
        res_ready = 1'b0;
        s0 = starts;
        issue_cmd(16'd0, 16'd5);
        k = 0;
        while ((starts - s0) < 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rst: third start reached", 32'(starts - s0), 32'd3);
        check("rst: queued before reset", 32'(res_valid), 32'd1);
        check("rst: busy before reset", 32'(busy), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("rst: res_valid", 32'(res_valid), 32'd0);
        check("rst: busy", 32'(busy), 32'd0);
        check("rst: cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst: fib_start", 32'(fib_start), 32'd0);
        check("rst: fib_din", 32'(fib_din), 32'd0);
        check("rst: res_n", 32'(res_n), 32'd0);
        check("rst: res_value", 32'(res_value), 32'd0);
        check("rst: res_ovf", 32'(res_ovf), 32'd0);
        check("rst: timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        res_ready = 1'b1;
        run_vec('{16'd3, 16'd3, 1, 3, 1}, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
